// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer for the execute stage: shift-add multiplier and
// restoring divider sharing one 2*WIDTH accumulator, writing HI/LO on completion.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    // Handshake: start is a level request held by the stalled requester; it is
    // accepted on the edge where state is IDLE or DONE and flush is low. done is a
    // one-cycle pulse coincident with hi/lo showing the new result.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               b_zero;
    logic [WIDTH-1:0]   ma;
    logic [WIDTH-1:0]   mb;
    logic [2*WIDTH-1:0] acc;

    logic               signed_op;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               accept;

    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     trial;
    logic               qbit;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] acc_next;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign signed_op = ~op[0];
    assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;
    assign accept    = start && !flush && (state == IDLE || state == DONE);

    assign stall     = accept || (state == BUSY);
    assign busy      = (state == BUSY);
    assign dbg_state = state;

    always_comb begin
        // Multiply: low half holds the remaining multiplier bits, high half the partial sum.
        msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, ma} : '0);
        mul_next = {msum, acc[WIDTH-1:1]};

        // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
        trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        qbit     = (trial >= {1'b0, mb});
        rem_next = qbit ? WIDTH'(trial - {1'b0, mb}) : trial[WIDTH-1:0];
        div_next = {rem_next, acc[WIDTH-2:0], qbit};

        acc_next = is_div ? div_next : mul_next;

        prod_fix = neg_q ? -acc_next : acc_next;
        quo_fix  = neg_q ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
        rem_fix  = neg_r ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];

        if (is_div) begin
            res_hi = rem_fix;
            res_lo = b_zero ? '1 : quo_fix;
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            ma     <= '0;
            mb     <= '0;
            acc    <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            state  <= BUSY;
                            cnt    <= '0;
                            is_div <= op[1];
                            neg_q  <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r  <= signed_op && a[WIDTH-1];
                            b_zero <= (b == '0);
                            ma     <= a_mag;
                            mb     <= b_mag;
                            acc    <= op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                        end else begin
                            state <= IDLE;
                        end
                    end
                    BUSY: begin
                        acc <= acc_next;
                        cnt <= cnt + 1'b1;
                        // The last iteration's result is sign-corrected and written in one edge.
                        if (cnt == CW'(WIDTH - 1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            hi    <= res_hi;
                            lo    <= res_lo;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
